// File: rtl/if_prefetch_pkg.sv
// Shared CPU definitions for the instruction-fetch prefetcher: widths, buffer
// depth default and the fetch FSM state encoding.
package if_prefetch_pkg;

   localparam int PF_INST_W = 32;
   localparam int PF_REG_W  = 32;
   localparam int PF_DEPTH  = 4;

   typedef enum logic [1:0] {
      PF_IDLE  = 2'd0,
      PF_REQ   = 2'd1,
      PF_DRAIN = 2'd2
   } pf_state_e;

endpackage

// File: rtl/if_prefetch_pf_fifo.sv
// Synchronous instruction buffer: DEPTH entries of {inst, pc_plus4}, with a
// single-cycle flush. Overflow/underflow are only flagged, never blocked.
module pf_fifo
   import if_prefetch_pkg::*;
#(
   parameter int DEPTH = PF_DEPTH,
   parameter int WIDTH = 2 * PF_INST_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // The fetch FSM's space accounting makes both of these unreachable.
   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!(push && !flush && count_q == CNT_W'(DEPTH)))
            else $error("pf_fifo: push while full");
         assert (!(pop && !flush && count_q == '0))
            else $error("pf_fifo: pop while empty");
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign empty   = (count_q == '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues sequential fetches into a small buffer ahead
// of decode, and flushes/redirects on a taken branch from the MEM stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PF_IDLE  | no request outstanding; issue fetchPC next edge if space
// PF_REQ   | request to fetchPC outstanding; ack data is pushed
// PF_DRAIN | stale request outstanding after redirect; ack data dropped
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int DEPTH  = PF_DEPTH,
   parameter int INST_W = PF_INST_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iRedirect,
   input  logic [INST_W-1:0] iRedirectPC,
   output logic              oMemReq,
   output logic [INST_W-1:0] oMemAddr,
   input  logic              iMemAck,
   input  logic [INST_W-1:0] iMemData,
   output logic              oInstValid,
   output logic [INST_W-1:0] oInst,
   output logic [INST_W-1:0] oPCPlus4,
   input  logic              iInstReady
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   pf_state_e         state_q, state_d;
   logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [INST_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_req_q, mem_req_d;
   logic [INST_W-1:0] pc_plus4;
   logic [INST_W-1:0] redirect_pc;
   logic              push, pop, empty;
   logic [CNT_W-1:0]  count, count_after;
   logic [2*INST_W-1:0] head;
   logic              unused_pc_lsbs;

   assign pc_plus4       = fetch_pc_q + INST_W'(4);
   assign redirect_pc    = {iRedirectPC[INST_W-1:2], 2'b00};
   assign unused_pc_lsbs = ^iRedirectPC[1:0];

   // A redirect flushes the buffer, so it also cancels this cycle's push/pop.
   assign pop         = ~empty & iInstReady & ~iRedirect;
   assign push        = (state_q == PF_REQ) & iMemAck & ~iRedirect;
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         PF_IDLE: begin
            if (iRedirect) begin
               fetch_pc_d = redirect_pc;
            end else if (count < CNT_W'(DEPTH)) begin
               state_d    = PF_REQ;
               mem_addr_d = fetch_pc_q;
            end
         end
         PF_REQ: begin
            if (iRedirect) begin
               fetch_pc_d = redirect_pc;
               state_d    = iMemAck ? PF_IDLE : PF_DRAIN;
            end else if (iMemAck) begin
               fetch_pc_d = pc_plus4;
               if (count_after < CNT_W'(DEPTH)) mem_addr_d = pc_plus4;
               else                              state_d    = PF_IDLE;
            end
         end
         PF_DRAIN: begin
            // mem_addr_q holds the stale address until its ack returns.
            if (iRedirect) fetch_pc_d = redirect_pc;
            if (iMemAck)   state_d    = PF_IDLE;
         end
         default: state_d = PF_IDLE;
      endcase
      mem_req_d = (state_d != PF_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= PF_IDLE;
         fetch_pc_q <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
      end
   end

   pf_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * INST_W)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (push),
      .pop     (pop),
      .flush   (iRedirect),
      .wr_data ({iMemData, pc_plus4}),
      .rd_data (head),
      .count   (count),
      .empty   (empty)
   );

   assign oMemReq    = mem_req_q;
   assign oMemAddr   = mem_addr_q;
   assign oInstValid = ~empty;
   assign oInst      = head[2*INST_W-1:INST_W];
   assign oPCPlus4   = head[INST_W-1:0];

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: variable-latency memory model plus an architectural
// fetch-stream model (sequential PCs restarting at each redirect target).
module tb_if_prefetch;

   logic        clk;
   logic        resetn;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
   logic        oMemReq;
   logic [31:0] oMemAddr;
   logic        iMemAck;
   logic [31:0] iMemData;
   logic        oInstValid;
   logic [31:0] oInst;
   logic [31:0] oPCPlus4;
   logic        iInstReady;

   int vectors     = 0;
   int miscompares = 0;
   int ack_cnt     = 0;
   int pops        = 0;
   int dly_min     = 0;
   int dly_max     = 0;
   logic [31:0] exp_pc = '0;

   if_prefetch #(.DEPTH(4), .INST_W(32)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iRedirect   (iRedirect),
      .iRedirectPC (iRedirectPC),
      .oMemReq     (oMemReq),
      .oMemAddr    (oMemAddr),
      .iMemAck     (iMemAck),
      .iMemData    (iMemData),
      .oInstValid  (oInstValid),
      .oInst       (oInst),
      .oPCPlus4    (oPCPlus4),
      .iInstReady  (iInstReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Memory: latches each new request, acks after dly_min..dly_max wait cycles.
   initial begin : mem_model
      bit          pend;
      int          dly, waited;
      logic [31:0] req_addr;
      pend = 0; dly = 0; waited = 0; req_addr = '0;
      iMemAck = 1'b0;
      iMemData = '0;
      forever begin
         @(negedge clk);
         if (!resetn || !oMemReq) begin
            iMemAck = 1'b0;
            pend = 0;
         end else begin
            if (!pend) begin
               pend = 1;
               req_addr = oMemAddr;
               dly = int'($urandom_range(dly_max, dly_min));
               waited = 0;
            end else begin
               chk("addr_stable", oMemAddr, req_addr);
            end
            if (waited >= dly) begin
               iMemAck = 1'b1;
               iMemData = mem_word(oMemAddr);
               pend = 0;
               ack_cnt++;
            end else begin
               iMemAck = 1'b0;
               waited++;
            end
         end
      end
   end

   // Called at a negedge: drive inputs, check any popped head against the
   // model, clock once, and return at the following negedge.
   task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
      iInstReady  = rdy;
      iRedirect   = redir;
      iRedirectPC = tgt;
      if (oInstValid && rdy && !redir) begin
         chk("stream_inst", oInst, mem_word(exp_pc));
         chk("stream_pc4", oPCPlus4, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (redir) exp_pc = {tgt[31:2], 2'b00};
      @(posedge clk);
      #1;
      if (redir) chk("flush_empty", {31'd0, oInstValid}, 32'd0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      iRedirect = 1'b0;
      iInstReady = 1'b0;
      iRedirectPC = '0;
      repeat (2) @(negedge clk);
      exp_pc = '0;
      ack_cnt = 0;
      resetn = 1'b1;
   endtask

   initial begin : main
      int n;
      resetn = 1'b0;
      iRedirect = 1'b0;
      iRedirectPC = '0;
      iInstReady = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_memreq", {31'd0, oMemReq}, 32'd0);
      chk("rst_memaddr", oMemAddr, 32'd0);
      chk("rst_valid", {31'd0, oInstValid}, 32'd0);
      chk("rst_inst", oInst, 32'd0);
      chk("rst_pc4", oPCPlus4, 32'd0);
      @(negedge clk);
      exp_pc = '0;
      resetn = 1'b1;

      // zero-wait streaming, one instruction per cycle
      dly_min = 0; dly_max = 0;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 32'd0);
         chk("zw_memreq", {31'd0, oMemReq}, 32'd1);
         chk("zw_addr", oMemAddr, 32'(4 * (k - 1)));
         if (k >= 2) begin
            chk("zw_valid", {31'd0, oInstValid}, 32'd1);
            chk("zw_inst", oInst, 32'(32'h100 + 4 * (k - 2)));
            chk("zw_pc4", oPCPlus4, 32'(4 * (k - 1)));
         end
      end

      // decode stall with 2-cycle memory fills exactly DEPTH entries
      do_reset();
      dly_min = 1; dly_max = 1;
      repeat (10) step(1'b0, 1'b0, 32'd0);
      chk("stall_pushes", 32'(ack_cnt), 32'd4);
      chk("stall_memreq", {31'd0, oMemReq}, 32'd0);
      for (int j = 0; j < 4; j++) begin
         chk("stall_valid", {31'd0, oInstValid}, 32'd1);
         chk("stall_inst", oInst, 32'(32'h100 + 4 * j));
         step(1'b1, 1'b0, 32'd0);
      end

      // redirect while a 3-cycle request to 0x8 is pending
      do_reset();
      dly_min = 2; dly_max = 2;
      n = 0;
      while (!(oMemReq && oMemAddr == 32'h8) && n < 30) begin
         step(1'b0, 1'b0, 32'd0);
         n++;
      end
      chk("rd_wait_req8", {31'd0, oMemReq && oMemAddr == 32'h8}, 32'd1);
      step(1'b0, 1'b1, 32'h40);
      chk("rd_drain_addr", oMemAddr, 32'h8);
      n = 0;
      while (!(oMemReq && oMemAddr != 32'h8) && n < 30) begin
         step(1'b0, 1'b0, 32'd0);
         n++;
      end
      chk("rd_next_addr", oMemAddr, 32'h40);
      n = 0;
      while (!oInstValid && n < 30) begin
         step(1'b0, 1'b0, 32'd0);
         n++;
      end
      chk("rd_first_inst", oInst, mem_word(32'h40));
      chk("rd_first_pc4", oPCPlus4, 32'h44);

      // redirect to an unaligned target coinciding with ack and pop
      do_reset();
      dly_min = 0; dly_max = 0;
      repeat (4) step(1'b1, 1'b0, 32'd0);
      chk("ra_pre_valid", {31'd0, oInstValid}, 32'd1);
      step(1'b1, 1'b1, 32'h22);
      chk("ra_idle", {31'd0, oMemReq}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      chk("ra_req", {31'd0, oMemReq}, 32'd1);
      chk("ra_addr", oMemAddr, 32'h20);
      step(1'b1, 1'b0, 32'd0);
      chk("ra_inst", oInst, mem_word(32'h20));
      chk("ra_pc4", oPCPlus4, 32'h24);

      // asynchronous reset in the middle of a request to 0x14
      do_reset();
      dly_min = 3; dly_max = 3;
      n = 0;
      while (!(oMemReq && oMemAddr == 32'h14) && n < 80) begin
         step(1'b1, 1'b0, 32'd0);
         n++;
      end
      chk("ar_wait_req14", {31'd0, oMemReq && oMemAddr == 32'h14}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("ar_memreq", {31'd0, oMemReq}, 32'd0);
      chk("ar_memaddr", oMemAddr, 32'd0);
      chk("ar_valid", {31'd0, oInstValid}, 32'd0);
      chk("ar_inst", oInst, 32'd0);
      chk("ar_pc4", oPCPlus4, 32'd0);
      repeat (2) @(negedge clk);
      exp_pc = '0;
      resetn = 1'b1;
      step(1'b1, 1'b0, 32'd0);
      chk("ar_restart_req", {31'd0, oMemReq}, 32'd1);
      chk("ar_restart_addr", oMemAddr, 32'd0);

      // random latency, ready and redirects against the stream model
      do_reset();
      dly_min = 0; dly_max = 5;
      pops = 0;
      for (int c = 0; c < 10000; c++) begin
         step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, $urandom);
      end
      chk("rand_progress", {31'd0, pops > 1000}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH SHALL be: default 4; number of instruction-buffer entries; power of two, minimum 2.
REQ-002 Parameter INST_W SHALL be: default 32; instruction width and address width.
REQ-003 clk SHALL be an input, 1 bit; the single clock, rising edge.
REQ-004 resetn SHALL be an input, 1 bit; asynchronous, active-low reset.
REQ-005 iRedirect SHALL be an input, 1 bit; taken-branch redirect pulse from the MEM-stage PC source select.
REQ-006 iRedirectPC SHALL be an input, INST_W bits; branch target byte address.
REQ-007 oMemReq SHALL be an output, 1 bit; instruction-memory read request.
REQ-008 oMemAddr SHALL be an output, INST_W bits; byte address of the request.
REQ-009 iMemAck SHALL be an input, 1 bit; the memory returns iMemData this cycle.
REQ-010 iMemData SHALL be an input, INST_W bits; instruction word returned by memory.
REQ-011 oInstValid SHALL be an output, 1 bit; the head of the buffer is valid.
REQ-012 oInst SHALL be an output, INST_W bits; head instruction, feeding the IF/ID instruction register.
REQ-013 oPCPlus4 SHALL be an output, INST_W bits; head fetch address + 4, feeding the IF/ID PC register.
REQ-014 iInstReady SHALL be an input, 1 bit; the decode stage accepts the head this cycle (the decode stage holds it low during a stall).

Function
REQ-015 The FSM SHALL have the states IDLE, REQ and DRAIN; oMemReq SHALL be high exactly in REQ and DRAIN, and SHALL be driven from a register.
REQ-016 Space accounting: a new request SHALL issue only when count + outstanding < DEPTH; outstanding is 1 in REQ and DRAIN.
REQ-017 IDLE→REQ SHALL occur on the next edge when space exists and iRedirect=0; oMemAddr SHALL equal fetchPC.
REQ-018 In REQ and DRAIN, oMemReq and oMemAddr SHALL stay stable until the edge where iMemAck=1; an ack may arrive in the first request cycle.
REQ-019 REQ with ack and no redirect: {iMemData, fetchPC+4} SHALL be pushed; fetchPC SHALL increment by 4 (mod 2^INST_W, wrap permitted); the state SHALL stay in REQ with the new address if space remains after the push, else go to IDLE.
REQ-020 With a zero-wait memory (ack every request cycle) and iInstReady=1, throughput SHALL be one instruction per cycle.
REQ-021 Latency: data acked at edge N SHALL drive oInstValid=1 and oInst from the cycle after edge N.
REQ-022 Pop: at an edge with oInstValid & iInstReady, the head SHALL be removed; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 Redirect: at an edge with iRedirect=1, the buffer SHALL be flushed (count=0, any pop ignored), and fetchPC SHALL become {iRedirectPC[INST_W-1:2], 2'b00}.
REQ-024 Redirect in IDLE SHALL go to IDLE, which issues the new PC on the following edge.
REQ-025 Redirect in REQ without ack SHALL go to DRAIN.
REQ-026 Redirect in REQ coinciding with ack SHALL discard the data and go to IDLE.
REQ-027 In DRAIN, the returning ack data SHALL be discarded, then the state SHALL go to IDLE; no push SHALL occur.
REQ-028 Redirect in DRAIN SHALL overwrite fetchPC and stay in DRAIN (or go to IDLE if ack is present).
REQ-029 oInstValid SHALL be 0 when the buffer is empty; oInst and oPCPlus4 are don't-care then.
REQ-030 A push while full SHALL be impossible by REQ-016; an assertion SHALL flag it.

Reset
REQ-031 While resetn=0, and asynchronously: state=IDLE, fetchPC=0, count=0, rd/wr pointers=0, oMemReq=0, oMemAddr=0, oInstValid=0, oInst=0, oPCPlus4=0.
REQ-032 On reset assertion mid-request, the request SHALL be abandoned; the memory is also reset by resetn.
REQ-033 The first request SHALL be for address 0 on the first edge after resetn rises.

Structure
REQ-034 The shared cpu defines package SHALL hold INST_W, REG_W, the PF_DEPTH default and the FSM state encoding (2 bits: IDLE=0, REQ=1, DRAIN=2).
REQ-035 There SHALL be one sub-module, pf_fifo: a synchronous FIFO with DEPTH×(2·INST_W) storage, push, pop, flush, count and empty outputs, and no internal protection beyond assertions.
REQ-036 The FSM, fetchPC and space accounting SHALL reside in if_prefetch.

Verification
REQ-037 Reset release with zero-wait memory (mem[a]=a+0x100) and iInstReady=1 -> oMemAddr 0,4,8,… on consecutive cycles; oInst 0x100,0x104,… from cycle 2; oPCPlus4 4,8,…
REQ-038 iInstReady=0 held 10 cycles with a 2-cycle-ack memory -> exactly 4 pushes, then oMemReq=0; on ready, the words for 0,4,8,0xC pop in order with no loss.
REQ-039 Redirect to 0x40 while a 3-cycle request to 0x8 is pending -> the 0x8 data is dropped, the next oMemAddr is 0x40, and the first valid oInst is mem[0x40].
REQ-040 Redirect to 0x22 coinciding with ack and pop -> the buffer is empty next cycle, the ack data is not seen, and the next request address is 0x20.
REQ-041 Random ack delay 0–5, random ready and redirects, 10k cycles -> the oInst/oPCPlus4 stream matches the reference PC model; no overflow assertion fires.
REQ-042 resetn pulsed low during REQ at address 0x14 -> all outputs are 0 immediately, and the request restarts at 0 after release.
